// File: rtl/conv_window_feeder_if.sv
// Bus bundle for conv_window_feeder: frame/filter control, pixel stream in and
// serial window stream out to the convolution accelerator.
interface conv_window_feeder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 8
);
  logic              start;
  logic              load_filter;
  logic [DIM_W-1:0]  img_width;
  logic [DIM_W-1:0]  img_height;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] acc_data;
  logic              acc_valid;
  logic              acc_filter;
  logic              acc_last;
  logic              busy;
  logic              frame_done;

  // Upstream controller / pixel source
  modport master (
    output start, load_filter, img_width, img_height, pix_data, pix_valid,
    input  pix_ready, acc_data, acc_valid, acc_filter, acc_last, busy, frame_done
  );

  // Window feeder
  modport slave (
    input  start, load_filter, img_width, img_height, pix_data, pix_valid,
    output pix_ready, acc_data, acc_valid, acc_filter, acc_last, busy, frame_done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Turns a row-major pixel stream into serial 3x3 windows (stride 1, no padding)
// for the convolution accelerator; also passes 9-word filter loads through.
module conv_window_feeder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IMG_W_MAX = 64,
  parameter int unsigned DIM_W     = 8
) (
  input logic                 clk,
  input logic                 reset,
  conv_window_feeder_if.slave bus
);
  localparam int unsigned LB_AW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
  localparam int unsigned WIN_N = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADF = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state,  w_state_nxt;
  logic [DIM_W-1:0]  r_width,  w_width_nxt;
  logic [DIM_W-1:0]  r_height, w_height_nxt;
  logic [DIM_W-1:0]  r_row,    w_row_nxt;
  logic [DIM_W-1:0]  r_col,    w_col_nxt;
  logic [3:0]        r_word,   w_word_nxt;
  logic              r_last_px, w_last_px_nxt;
  logic              r_from_lf, w_from_lf_nxt;
  logic [DATA_W-1:0] r_win [WIN_N];
  logic [DATA_W-1:0] w_win_nxt [WIN_N];

  logic              r_pix_ready,  w_pix_ready_nxt;
  logic [DATA_W-1:0] r_acc_data,   w_acc_data_nxt;
  logic              r_acc_valid,  w_acc_valid_nxt;
  logic              r_acc_filter, w_acc_filter_nxt;
  logic              r_acc_last,   w_acc_last_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_frame_done, w_frame_done_nxt;

  // Line buffers: lb0 holds the previous row, lb1 the row before it
  logic [DATA_W-1:0] r_lb0 [IMG_W_MAX];
  logic [DATA_W-1:0] r_lb1 [IMG_W_MAX];

  logic             w_fire;
  logic             w_dims_bad;
  logic [LB_AW-1:0] w_lb_idx;

  assign w_fire     = bus.pix_valid && r_pix_ready;
  assign w_lb_idx   = r_col[LB_AW-1:0];
  assign w_dims_bad = (bus.img_width < DIM_W'(3)) || (bus.img_height < DIM_W'(3)) ||
                      (bus.img_width > DIM_W'(IMG_W_MAX));

  always_ff @(posedge clk) begin
    if (r_state == S_FILL && w_fire) begin
      r_lb1[w_lb_idx] <= r_lb0[w_lb_idx];
      r_lb0[w_lb_idx] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_word       <= '0;
      r_last_px    <= 1'b0;
      r_from_lf    <= 1'b0;
      for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
      r_pix_ready  <= 1'b0;
      r_acc_data   <= '0;
      r_acc_valid  <= 1'b0;
      r_acc_filter <= 1'b0;
      r_acc_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_width      <= w_width_nxt;
      r_height     <= w_height_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_word       <= w_word_nxt;
      r_last_px    <= w_last_px_nxt;
      r_from_lf    <= w_from_lf_nxt;
      for (int i = 0; i < WIN_N; i++) r_win[i] <= w_win_nxt[i];
      r_pix_ready  <= w_pix_ready_nxt;
      r_acc_data   <= w_acc_data_nxt;
      r_acc_valid  <= w_acc_valid_nxt;
      r_acc_filter <= w_acc_filter_nxt;
      r_acc_last   <= w_acc_last_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_width_nxt      = r_width;
    w_height_nxt     = r_height;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_word_nxt       = r_word;
    w_last_px_nxt    = r_last_px;
    w_from_lf_nxt    = r_from_lf;
    w_win_nxt        = r_win;
    w_acc_data_nxt   = r_acc_data;
    w_acc_valid_nxt  = 1'b0;
    w_acc_last_nxt   = 1'b0;
    w_acc_filter_nxt = r_acc_filter;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_dims_bad) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt      = S_FILL;
            w_width_nxt      = bus.img_width;
            w_height_nxt     = bus.img_height;
            w_row_nxt        = '0;
            w_col_nxt        = '0;
            w_last_px_nxt    = 1'b0;
            w_from_lf_nxt    = 1'b0;
            w_acc_filter_nxt = 1'b0;
          end
        end else if (bus.load_filter) begin
          w_state_nxt      = S_LOADF;
          w_word_nxt       = '0;
          w_from_lf_nxt    = 1'b1;
          w_acc_filter_nxt = 1'b1;
        end
      end

      // word==9 is the drain cycle showing the 9th coefficient
      S_LOADF: begin
        if (r_word == 4'd9) begin
          w_state_nxt = S_GAP;
        end else if (w_fire) begin
          w_acc_data_nxt  = bus.pix_data;
          w_acc_valid_nxt = 1'b1;
          w_acc_last_nxt  = (r_word == 4'd8);
          w_word_nxt      = 4'(r_word + 4'd1);
        end
      end

      S_FILL: begin
        if (w_fire) begin
          for (int r = 0; r < 3; r++) begin
            w_win_nxt[3*r]     = r_win[3*r + 1];
            w_win_nxt[3*r + 1] = r_win[3*r + 2];
          end
          w_win_nxt[2] = r_lb1[w_lb_idx];
          w_win_nxt[5] = r_lb0[w_lb_idx];
          w_win_nxt[8] = bus.pix_data;
          if (r_col == r_width - DIM_W'(1)) begin
            w_col_nxt = '0;
            w_row_nxt = DIM_W'(r_row + DIM_W'(1));
          end else begin
            w_col_nxt = DIM_W'(r_col + DIM_W'(1));
          end
          // Requiring col>=2 keeps the previous row's tail out of the window
          if (r_row >= DIM_W'(2) && r_col >= DIM_W'(2)) begin
            w_state_nxt     = S_EMIT;
            w_word_nxt      = '0;
            w_acc_data_nxt  = w_win_nxt[0];
            w_acc_valid_nxt = 1'b1;
            w_last_px_nxt   = (r_row == r_height - DIM_W'(1)) &&
                              (r_col == r_width - DIM_W'(1));
          end
        end
      end

      S_EMIT: begin
        if (r_word == 4'd8) begin
          w_state_nxt = S_GAP;
        end else begin
          w_word_nxt      = 4'(r_word + 4'd1);
          w_acc_data_nxt  = r_win[w_word_nxt];
          w_acc_valid_nxt = 1'b1;
          w_acc_last_nxt  = (r_word == 4'd7);
        end
      end

      // One idle cycle lets the accelerator clear its word counter
      S_GAP: begin
        if (r_from_lf)      w_state_nxt = S_IDLE;
        else if (r_last_px) w_state_nxt = S_DONE;
        else                w_state_nxt = S_FILL;
      end

      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_pix_ready_nxt  = (w_state_nxt == S_FILL) ||
                       ((w_state_nxt == S_LOADF) && (w_word_nxt != 4'd9));
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_frame_done_nxt = (w_state_nxt == S_DONE);
  end

  assign bus.pix_ready  = r_pix_ready;
  assign bus.acc_data   = r_acc_data;
  assign bus.acc_valid  = r_acc_valid;
  assign bus.acc_filter = r_acc_filter;
  assign bus.acc_last   = r_acc_last;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed + randomized bench for conv_window_feeder; expected windows come from
// indexing a plain image array, timing from the accepted-pixel cycle log.
module tb_conv_window_feeder;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIM_W  = 8;

  logic clk;
  logic reset;

  conv_window_feeder_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

  conv_window_feeder #(.DATA_W(DATA_W), .IMG_W_MAX(64), .DIM_W(DIM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic              v;
    logic              last;
    logic              filt;
    logic              rdy;
    logic              busy;
    logic              done;
    logic              fire;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              log_q [$];
  logic [DATA_W-1:0] pix   [$];
  bit                rec;
  int                n_cmp;
  int                n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One log entry per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (rec) begin
      ent_t e;
      e.v    = bus.acc_valid;
      e.last = bus.acc_last;
      e.filt = bus.acc_filter;
      e.rdy  = bus.pix_ready;
      e.busy = bus.busy;
      e.done = bus.frame_done;
      e.fire = bus.pix_valid && bus.pix_ready;
      e.d    = bus.acc_data;
      log_q.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t get_ent(input int i);
    ent_t e;
    if (i >= 0 && i < log_q.size()) e = log_q[i];
    else e = 'x;
    return e;
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, " pix_ready"},  64'(bus.pix_ready),  64'(0));
    check({pfx, " acc_valid"},  64'(bus.acc_valid),  64'(0));
    check({pfx, " acc_data"},   64'(bus.acc_data),   64'(0));
    check({pfx, " acc_filter"}, 64'(bus.acc_filter), 64'(0));
    check({pfx, " acc_last"},   64'(bus.acc_last),   64'(0));
    check({pfx, " busy"},       64'(bus.busy),       64'(0));
    check({pfx, " frame_done"}, 64'(bus.frame_done), 64'(0));
  endtask

  // Entered and left at posedge+1. mode 0: always valid; 1: toggling; 2: random.
  // Modes 1/2 hold pix_valid high with junk data while pix_ready is low.
  task automatic drive_pixels(input int n, input int mode, input int stop_words,
                              output int acc, output bit stopped);
    int idx = 0;
    int cyc = 0;
    int seen = 0;
    bit fire;
    stopped = 1'b0;
    while (idx < n && cyc < 3000) begin
      if (mode == 0) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix[idx];
      end else if (!bus.pix_ready) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = 32'hBAD0_0000 | 32'(cyc);
      end else begin
        bus.pix_valid = (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
        bus.pix_data  = pix[idx];
      end
      @(negedge clk);
      fire = bus.pix_valid && bus.pix_ready;
      if (bus.acc_valid) seen++;
      if (stop_words > 0 && seen == stop_words) begin
        stopped = 1'b1;
        acc = idx;
        return;
      end
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    acc = idx;
  endtask

  task automatic pulse_start(input int w, input int h, input bit with_lf);
    bus.img_width   = DIM_W'(w);
    bus.img_height  = DIM_W'(h);
    bus.start       = 1'b1;
    bus.load_filter = with_lf;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.load_filter = 1'b0;
  endtask

  task automatic trail(input int n);
    repeat (n) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = $urandom;
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  // Reference: window (r0,c0) word k is img[r0 + k/3][c0 + k%3]
  task automatic analyze_frame(input string nm, input int w, input int h);
    int fires [$];
    int nvalid = 0;
    int ndone = 0;
    int nwin = (w - 2) * (h - 2);
    int first = -1;
    ent_t e;
    foreach (log_q[i]) begin
      if (log_q[i].fire) fires.push_back(i);
      if (log_q[i].v)    nvalid++;
      if (log_q[i].done) ndone++;
    end
    check({nm, " pixels accepted"}, 64'(fires.size()), 64'(w * h));
    check({nm, " word count"}, 64'(nvalid), 64'(9 * nwin));
    check({nm, " frame_done pulses"}, 64'(ndone), 64'(1));
    for (int wi = 0; wi < nwin; wi++) begin
      int r0 = wi / (w - 2);
      int c0 = wi % (w - 2);
      int p  = (r0 + 2) * w + (c0 + 2);
      first = (p < fires.size()) ? fires[p] + 1 : -1;
      for (int k = 0; k < 9; k++) begin
        logic [DATA_W-1:0] expd = pix[(r0 + k / 3) * w + c0 + k % 3];
        e = get_ent(first + k);
        check($sformatf("%s win%0d w%0d valid", nm, wi, k), 64'(e.v), 64'(1));
        check($sformatf("%s win%0d w%0d data", nm, wi, k), 64'(e.d), 64'(expd));
        check($sformatf("%s win%0d w%0d last", nm, wi, k), 64'(e.last), 64'(k == 8));
        check($sformatf("%s win%0d w%0d filter", nm, wi, k), 64'(e.filt), 64'(0));
        check($sformatf("%s win%0d w%0d ready", nm, wi, k), 64'(e.rdy), 64'(0));
      end
      e = get_ent(first + 9);
      check($sformatf("%s win%0d gap valid", nm, wi), 64'(e.v), 64'(0));
      check($sformatf("%s win%0d gap ready", nm, wi), 64'(e.rdy), 64'(0));
    end
    e = get_ent(first + 10);
    check({nm, " frame_done after last gap"}, 64'(e.done), 64'(1));
  endtask

  task automatic run_frame(input string nm, input int w, input int h, input int mode,
                           input bit with_lf);
    int acc;
    bit stopped;
    log_q.delete();
    rec = 1'b1;
    pulse_start(w, h, with_lf);
    drive_pixels(w * h, mode, 0, acc, stopped);
    trail(25);
    rec = 1'b0;
    analyze_frame(nm, w, h);
  endtask

  task automatic run_filter(input string nm, input int mode);
    int acc;
    bit stopped;
    int fires [$];
    int nvalid = 0;
    int ndone = 0;
    int f8;
    ent_t e;
    log_q.delete();
    rec = 1'b1;
    bus.load_filter = 1'b1;
    @(posedge clk); #1;
    bus.load_filter = 1'b0;
    drive_pixels(9, mode, 0, acc, stopped);
    trail(8);
    rec = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].fire) fires.push_back(i);
      if (log_q[i].v)    nvalid++;
      if (log_q[i].done) ndone++;
    end
    check({nm, " words accepted"}, 64'(fires.size()), 64'(9));
    check({nm, " words emitted"}, 64'(nvalid), 64'(9));
    check({nm, " no frame_done"}, 64'(ndone), 64'(0));
    for (int k = 0; k < 9; k++) begin
      int idx = (k < fires.size()) ? fires[k] + 1 : -1;
      e = get_ent(idx);
      check($sformatf("%s w%0d valid", nm, k), 64'(e.v), 64'(1));
      check($sformatf("%s w%0d data", nm, k), 64'(e.d), 64'(pix[k]));
      check($sformatf("%s w%0d last", nm, k), 64'(e.last), 64'(k == 8));
      check($sformatf("%s w%0d filter", nm, k), 64'(e.filt), 64'(1));
    end
    f8 = (fires.size() >= 9) ? fires[8] : -100;
    e = get_ent(f8 + 1);
    check({nm, " ready low after 9th"}, 64'(e.rdy), 64'(0));
    e = get_ent(f8 + 2);
    check({nm, " gap valid"}, 64'(e.v), 64'(0));
    check({nm, " gap filter held"}, 64'(e.filt), 64'(1));
    check({nm, " gap busy"}, 64'(e.busy), 64'(1));
    e = get_ent(f8 + 3);
    check({nm, " idle busy"}, 64'(e.busy), 64'(0));
    check({nm, " idle ready"}, 64'(e.rdy), 64'(0));
  endtask

  task automatic run_bad(input string nm, input int w, input int h);
    int nvalid = 0;
    int ndone = 0;
    int nrdy = 0;
    ent_t e;
    log_q.delete();
    rec = 1'b1;
    pulse_start(w, h, 1'b0);
    trail(6);
    rec = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].v)    nvalid++;
      if (log_q[i].done) ndone++;
      if (log_q[i].rdy)  nrdy++;
    end
    e = get_ent(1);
    check({nm, " frame_done after start"}, 64'(e.done), 64'(1));
    check({nm, " frame_done pulses"}, 64'(ndone), 64'(1));
    check({nm, " no acc_valid"}, 64'(nvalid), 64'(0));
    check({nm, " never ready"}, 64'(nrdy), 64'(0));
    e = get_ent(2);
    check({nm, " back to idle"}, 64'(e.busy), 64'(0));
  endtask

  initial begin
    int acc;
    bit stopped;
    n_cmp = 0;
    n_mis = 0;
    rec   = 1'b0;
    bus.start       = 1'b0;
    bus.load_filter = 1'b0;
    bus.img_width   = '0;
    bus.img_height  = '0;
    bus.pix_data    = '0;
    bus.pix_valid   = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back(32'h0100_0000 * 32'(i + 1));
    run_filter("filter b2b", 0);

    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(32'(i));
    run_frame("4x4", 4, 4, 0, 1'b0);

    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back(32'(i));
    run_frame("3x3", 3, 3, 0, 1'b0);

    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(32'(i));
    run_frame("4x4 toggled", 4, 4, 1, 1'b0);

    run_bad("width2", 2, 4);
    run_bad("height2", 5, 2);
    run_bad("width65", 65, 4);

    // Abort mid-group: reset lands while the 4th word of the first window is out
    pix.delete();
    for (int i = 0; i < 25; i++) pix.push_back($urandom);
    log_q.delete();
    rec = 1'b1;
    pulse_start(5, 5, 1'b0);
    drive_pixels(25, 0, 4, acc, stopped);
    rec = 1'b0;
    check("abort point reached", 64'(stopped), 64'(1));
    reset = 1'b0;
    #1;
    check_outputs_zero("async reset");
    bus.pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no partial group after reset", 64'(bus.acc_valid), 64'(0));
    end
    @(posedge clk); #1;
    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back($urandom);
    run_frame("3x3 after reset", 3, 3, 2, 1'b0);

    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back($urandom);
    run_filter("filter random", 2);

    for (int t = 0; t < 4; t++) begin
      int w = int'($urandom_range(3, 10));
      int h = int'($urandom_range(3, 9));
      pix.delete();
      for (int i = 0; i < w * h; i++) pix.push_back($urandom);
      run_frame($sformatf("rand%0d %0dx%0d", t, w, h), w, h, 2, (t == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
